// File: rtl/zap_fetch_pc_gen_pkg.sv
// Shared fetch-stage definitions: PC generator FSM states and PC step sizes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package zap_fetch_pc_gen_pkg;

    // BOOT : out of reset, no fetch issued yet
    // RUN  : normal fetching
    // HOLD : a flush arrived during a stall and waits in the pending register
    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_t;

    localparam logic [31:0] PC_STEP_ARM   = 32'd4;
    localparam logic [31:0] PC_STEP_THUMB = 32'd2;

    function automatic logic [31:0] pc_step(input logic thumb);
        return thumb ? PC_STEP_THUMB : PC_STEP_ARM;
    endfunction

endpackage

// File: rtl/zap_pc_align.sv
// Forces a redirect target onto an instruction boundary for the current ISA state.
// Latency: purely combinational.
// Backpressure: none.
//
// Ports:
//   pc         : raw redirect target
//   thumb      : 1 = 16-bit stream (clear bit 0), 0 = 32-bit stream (clear bits 1:0)
//   pc_aligned : aligned target
module zap_pc_align (
    input  logic [31:0] pc,
    input  logic        thumb,
    output logic [31:0] pc_aligned
);

    assign pc_aligned = pc & ~(thumb ? 32'h0000_0001 : 32'h0000_0003);

endmodule

// File: rtl/zap_fetch_pc_gen.sv
// Fetch PC generator: sequential/flush/BTB-redirect address selection for I-cache and BTB.
// Latency: a redirect or flush sampled in cycle N is on o_rd_addr in cycle N+1.
// Backpressure: i_stall freezes all outputs; a flush seen while stalled is parked until the stall drops.
//
// Ports:
//   i_clk, i_reset_n         : clock, asynchronous active-low reset
//   i_stall                  : pipeline stall (also feeds the BTB stall input)
//   i_clear, i_clear_pc      : flush from execute and its target
//   i_thumb                  : 1 = 16-bit instructions, 0 = 32-bit
//   i_clear_from_btb,
//   i_pc_from_btb            : BTB predicted-taken redirect and target
//   o_rd_addr                : current fetch address (BTB read / I-cache)
//   o_rd_addr_del            : o_rd_addr one unstalled cycle ago (BTB tag compare)
//   o_valid                  : o_rd_addr is a real fetch
//   o_squash                 : instruction at o_rd_addr_del is wrong-path
//   o_btb_redirect_cnt       : saturating count of honoured BTB redirects
//
// Build option: define ZAP_FETCH_STATS_EN to build the redirect counter;
// without it o_btb_redirect_cnt is constant zero and no counter flops exist.
module zap_fetch_pc_gen
    import zap_fetch_pc_gen_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          CNT_WDT      = 16
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_stall,
    input  logic               i_clear,
    input  logic [31:0]        i_clear_pc,
    input  logic               i_thumb,
    input  logic               i_clear_from_btb,
    input  logic [31:0]        i_pc_from_btb,
    output logic [31:0]        o_rd_addr,
    output logic [31:0]        o_rd_addr_del,
    output logic               o_valid,
    output logic               o_squash,
    output logic [CNT_WDT-1:0] o_btb_redirect_cnt
);

    fetch_state_t state, state_nxt;

    logic [31:0] rd_addr,     rd_addr_nxt;
    logic [31:0] rd_addr_del, rd_addr_del_nxt;
    logic        valid,       valid_nxt;
    logic        squash,      squash_nxt;
    logic [31:0] pend_pc,     pend_pc_nxt;

    logic [31:0] clear_pc_al;
    logic [31:0] btb_pc_al;
    logic [31:0] seq_pc;

    zap_pc_align u_align_clear (
        .pc         (i_clear_pc),
        .thumb      (i_thumb),
        .pc_aligned (clear_pc_al)
    );

    zap_pc_align u_align_btb (
        .pc         (i_pc_from_btb),
        .thumb      (i_thumb),
        .pc_aligned (btb_pc_al)
    );

    // 32-bit modulo add: the top of the address space wraps to zero.
    assign seq_pc = rd_addr + pc_step(i_thumb);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= ST_BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        rd_addr_nxt     = rd_addr;
        rd_addr_del_nxt = rd_addr_del;
        valid_nxt       = valid;
        squash_nxt      = squash;
        pend_pc_nxt     = pend_pc;

        case (state)
            ST_BOOT: begin
                // The first fetch is RESET_VECTOR itself, so the address does
                // not advance on the BOOT -> RUN transition.
                if (!i_stall) begin
                    state_nxt       = ST_RUN;
                    valid_nxt       = 1'b1;
                    rd_addr_del_nxt = rd_addr;
                end
            end

            ST_RUN: begin
                if (i_stall) begin
                    if (i_clear) begin
                        pend_pc_nxt = clear_pc_al;
                        state_nxt   = ST_HOLD;
                    end
                end else begin
                    rd_addr_del_nxt = rd_addr;
                    if (i_clear) begin
                        rd_addr_nxt = clear_pc_al;
                        squash_nxt  = 1'b0;
                    end else if (i_clear_from_btb) begin
                        // The slot fetched alongside the branch was sequential,
                        // so it is wrong-path once the prediction is taken.
                        rd_addr_nxt = btb_pc_al;
                        squash_nxt  = 1'b1;
                    end else begin
                        rd_addr_nxt = seq_pc;
                        squash_nxt  = 1'b0;
                    end
                end
            end

            ST_HOLD: begin
                if (i_stall) begin
                    if (i_clear) begin
                        pend_pc_nxt = clear_pc_al;
                    end
                end else begin
                    // The parked flush takes effect; a flush arriving on this
                    // very cycle is newer and wins. BTB input is stale here.
                    rd_addr_del_nxt = rd_addr;
                    rd_addr_nxt     = i_clear ? clear_pc_al : pend_pc;
                    squash_nxt      = 1'b0;
                    state_nxt       = ST_RUN;
                end
            end

            default: begin
                state_nxt = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rd_addr     <= RESET_VECTOR;
            rd_addr_del <= RESET_VECTOR;
            valid       <= 1'b0;
            squash      <= 1'b0;
            pend_pc     <= 32'h0000_0000;
        end else begin
            rd_addr     <= rd_addr_nxt;
            rd_addr_del <= rd_addr_del_nxt;
            valid       <= valid_nxt;
            squash      <= squash_nxt;
            pend_pc     <= pend_pc_nxt;
        end
    end

    assign o_rd_addr     = rd_addr;
    assign o_rd_addr_del = rd_addr_del;
    assign o_valid       = valid;
    assign o_squash      = squash;

`ifdef ZAP_FETCH_STATS_EN
    logic               btb_take;
    logic [CNT_WDT-1:0] redirect_cnt;

    // Same condition under which the FSM follows the BTB target.
    assign btb_take = (state == ST_RUN) && !i_stall && !i_clear && i_clear_from_btb;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            redirect_cnt <= '0;
        end else if (btb_take && (redirect_cnt != {CNT_WDT{1'b1}})) begin
            redirect_cnt <= redirect_cnt + 1'b1;
        end
    end

    assign o_btb_redirect_cnt = redirect_cnt;
`else
    assign o_btb_redirect_cnt = '0;
`endif

endmodule

// File: tb/tb_zap_fetch_pc_gen.sv
// Directed bench for zap_fetch_pc_gen: reset, sequential fetch, BTB and flush
// redirects, stalls with a parked flush, alignment, wrap and counter saturation.
// Expected values are hand-computed; counter expectations follow ZAP_FETCH_STATS_EN.
module tb_zap_fetch_pc_gen;

    localparam int CW = 2;

`ifdef ZAP_FETCH_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          stall;
    logic          clear;
    logic [31:0]   clear_pc;
    logic          thumb;
    logic          btb;
    logic [31:0]   btb_pc;
    logic [31:0]   rd_addr;
    logic [31:0]   rd_addr_del;
    logic          valid;
    logic          squash;
    logic [CW-1:0] cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    zap_fetch_pc_gen #(
        .RESET_VECTOR (32'h0000_0000),
        .CNT_WDT      (CW)
    ) dut (
        .i_clk              (clk),
        .i_reset_n          (rst_n),
        .i_stall            (stall),
        .i_clear            (clear),
        .i_clear_pc         (clear_pc),
        .i_thumb            (thumb),
        .i_clear_from_btb   (btb),
        .i_pc_from_btb      (btb_pc),
        .o_rd_addr          (rd_addr),
        .o_rd_addr_del      (rd_addr_del),
        .o_valid            (valid),
        .o_squash           (squash),
        .o_btb_redirect_cnt (cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected counter value after n honoured redirects (CNT_WDT = 2 saturates at 3).
    function automatic logic [31:0] cnt_exp(input int n);
        if (!STATS) return 32'd0;
        return (n > 3) ? 32'd3 : 32'(n);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_pc(input string tag, input logic [31:0] a, input logic [31:0] d);
        chk({tag, "_addr"}, rd_addr, a);
        chk({tag, "_del"},  rd_addr_del, d);
    endtask

    initial begin
        rst_n    = 1'b0;
        stall    = 1'b0;
        clear    = 1'b0;
        clear_pc = 32'h0;
        thumb    = 1'b0;
        btb      = 1'b0;
        btb_pc   = 32'h0;

        // Reset state
        #3;
        expect_pc("rst", 32'h0, 32'h0);
        chk("rst_valid",  {31'd0, valid},  32'd0);
        chk("rst_squash", {31'd0, squash}, 32'd0);
        chk("rst_cnt",    {30'd0, cnt},    32'd0);

        tick();
        tick();
        rst_n = 1'b1;
        chk("boot_valid", {31'd0, valid}, 32'd0);

        // Sequential ARM fetch: 0,4,8,C
        tick();
        chk("run_valid", {31'd0, valid}, 32'd1);
        expect_pc("seq0", 32'h0, 32'h0);
        tick();
        expect_pc("seq1", 32'h4, 32'h0);
        tick();
        expect_pc("seq2", 32'h8, 32'h4);
        tick();
        expect_pc("seq3", 32'hC, 32'h8);
        repeat (5) tick();
        chk("seq_20", rd_addr, 32'h20);

        // BTB redirect to unaligned target
        btb = 1'b1; btb_pc = 32'h0000_1003;
        tick();
        expect_pc("btb1", 32'h1000, 32'h20);
        chk("btb1_squash", {31'd0, squash}, 32'd1);
        chk("btb1_cnt",    {30'd0, cnt},    cnt_exp(1));

        // Flush and BTB together: flush wins, squash cleared, count unchanged
        btb_pc = 32'h0000_0800; clear = 1'b1; clear_pc = 32'h0000_0400;
        tick();
        expect_pc("clr_btb", 32'h400, 32'h1000);
        chk("clr_btb_squash", {31'd0, squash}, 32'd0);
        chk("clr_btb_cnt",    {30'd0, cnt},    cnt_exp(1));
        clear = 1'b0; btb = 1'b0;
        tick();
        expect_pc("after_clr", 32'h404, 32'h400);

        // Three stalled cycles, flush to 0x200 on the second
        stall = 1'b1;
        tick();
        expect_pc("stall1", 32'h404, 32'h400);
        chk("stall1_valid", {31'd0, valid}, 32'd1);
        clear = 1'b1; clear_pc = 32'h0000_0200;
        tick();
        expect_pc("stall2", 32'h404, 32'h400);
        clear = 1'b0; btb = 1'b1; btb_pc = 32'h0000_0900;
        tick();
        expect_pc("stall3", 32'h404, 32'h400);
        stall = 1'b0;
        tick();
        expect_pc("hold_rel", 32'h200, 32'h404);
        chk("hold_rel_squash", {31'd0, squash}, 32'd0);
        chk("hold_rel_cnt",    {30'd0, cnt},    cnt_exp(1));
        btb = 1'b0;
        tick();
        expect_pc("hold_seq", 32'h204, 32'h200);

        // Stall holds a pending squash
        btb = 1'b1; btb_pc = 32'h0000_3000;
        tick();
        expect_pc("btb2", 32'h3000, 32'h204);
        chk("btb2_squash", {31'd0, squash}, 32'd1);
        chk("btb2_cnt",    {30'd0, cnt},    cnt_exp(2));
        btb = 1'b0; stall = 1'b1;
        tick();
        expect_pc("sq_stall", 32'h3000, 32'h204);
        chk("sq_stall_squash", {31'd0, squash}, 32'd1);
        stall = 1'b0;
        tick();
        expect_pc("sq_rel", 32'h3004, 32'h3000);
        chk("sq_rel_squash", {31'd0, squash}, 32'd0);

        // Alignment of flush targets
        clear = 1'b1; clear_pc = 32'h0000_0123; thumb = 1'b0;
        tick();
        chk("al_arm", rd_addr, 32'h120);
        clear_pc = 32'h0000_1003; thumb = 1'b1;
        tick();
        chk("al_thumb", rd_addr, 32'h1002);

        // Thumb wrap
        clear_pc = 32'hFFFF_FFFC;
        tick();
        chk("tw0", rd_addr, 32'hFFFF_FFFC);
        clear = 1'b0;
        tick();
        chk("tw1", rd_addr, 32'hFFFF_FFFE);
        tick();
        chk("tw2", rd_addr, 32'h0000_0000);

        // ARM wrap
        thumb = 1'b0; clear = 1'b1; clear_pc = 32'hFFFF_FFFF;
        tick();
        chk("aw0", rd_addr, 32'hFFFF_FFFC);
        clear = 1'b0;
        tick();
        chk("aw1", rd_addr, 32'h0000_0000);

        // Thumb BTB alignment
        thumb = 1'b1; btb = 1'b1; btb_pc = 32'h0000_1003;
        tick();
        chk("btb_thumb", rd_addr, 32'h1002);
        chk("btb_thumb_cnt", {30'd0, cnt}, cnt_exp(3));
        btb = 1'b0; thumb = 1'b0;

        // Asynchronous reset in HOLD discards the parked flush
        stall = 1'b1; clear = 1'b1; clear_pc = 32'h0000_5000;
        tick();
        clear = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        expect_pc("arst", 32'h0, 32'h0);
        chk("arst_valid",  {31'd0, valid},  32'd0);
        chk("arst_squash", {31'd0, squash}, 32'd0);
        chk("arst_cnt",    {30'd0, cnt},    32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("boot_stall_valid", {31'd0, valid}, 32'd0);
        chk("boot_stall_addr",  rd_addr, 32'h0);
        stall = 1'b0;
        tick();
        chk("reboot_valid", {31'd0, valid}, 32'd1);
        chk("reboot_addr",  rd_addr, 32'h0);
        tick();
        chk("no_pend", rd_addr, 32'h4);

        // Counter saturation over five back-to-back redirects
        for (int k = 1; k <= 5; k++) begin
            btb = 1'b1; btb_pc = 32'(k) * 32'h100;
            tick();
            chk("sat_addr",   rd_addr, 32'(k) * 32'h100);
            chk("sat_squash", {31'd0, squash}, 32'd1);
            chk("sat_cnt",    {30'd0, cnt},    cnt_exp(k));
        end
        btb = 1'b0;
        tick();
        chk("sat_end_squash", {31'd0, squash}, 32'd0);
        chk("sat_end_addr",   rd_addr, 32'h504);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
